// File: rtl/re2_copro_axil_regs_if.sv
// AXI4-Lite slave bus bundle for the regex coprocessor register file.
interface re2_copro_axil_regs_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/re2_copro_axil_regs.sv
// AXI4-Lite register file for the regex coprocessor: config regs, status/result,
// core start/done handshake. Optional irq_o output enabled by RE2_COPRO_IRQ_EN.
module re2_copro_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned RESULT_WIDTH       = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  re2_copro_axil_regs_if.slave    s_axi,
  output logic                    core_start_o,
  input  logic                    core_busy_i,
  input  logic                    core_done_i,
  input  logic [RESULT_WIDTH-1:0] core_result_i
`ifdef RE2_COPRO_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          awready_q, awready_d, wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  logic [3:0][DW-1:0] regs_q, regs_d;
  logic               done_q, done_d, rej_q, rej_d, start_q, start_d;
  logic [DW-1:0]      result_q, result_d;
  logic               irq_q, irq_d;

  logic          aw_hs, w_hs, wr_commit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [2:0]    wr_idx, rd_idx;
  logic          ar_hs;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(SW); i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Write channel: independent AW/W capture, commit, B response; core handshake.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    done_d    = done_q;
    rej_d     = rej_q;
    result_d  = result_q;
    start_d   = 1'b0;
    wr_commit = 1'b0;

    aw_hs   = s_axi.S_AXI_AWVALID & awready_q;
    w_hs    = s_axi.S_AXI_WVALID & wready_q;
    wr_addr = aw_held_q ? awaddr_q : s_axi.S_AXI_AWADDR;
    wr_data = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
    wr_strb = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
    wr_idx  = wr_addr[4:2];

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
          wr_commit = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_idx[2] ? RESP_SLVERR : RESP_OKAY;
          wstate_d  = W_RESP;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    if (wr_commit && !wr_idx[2]) begin
      regs_d[wr_idx[1:0]] = merge_bytes(regs_q[wr_idx[1:0]], wr_data, wr_strb);
      if (wr_idx[1:0] == 2'd0) begin
        if (wr_data[1]) begin
          done_d = 1'b0;
          rej_d  = 1'b0;
        end
        if (wr_strb[0] && wr_data[0]) begin
          if (core_busy_i) rej_d = 1'b1;
          else start_d = 1'b1;
        end
      end
    end

    // Completion wins over a simultaneous clear.
    if (core_done_i) begin
      done_d   = 1'b1;
      result_d = DW'(core_result_i);
    end

    irq_d = regs_q[0][2] & done_q;
  end

  // Read channel: register the selected word on AR handshake, hold until RREADY.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_hs     = s_axi.S_AXI_ARVALID & arready_q;
    rd_idx    = s_axi.S_AXI_ARADDR[4:2];

    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = RESP_OKAY;
          rstate_d  = R_DATA;
          case (rd_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rdata_d = regs_q[rd_idx[1:0]];
            3'd4:    rdata_d = DW'({rej_q, done_q, core_busy_i});
            3'd5:    rdata_d = result_q;
            default: begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      regs_q    <= '0;
      done_q    <= 1'b0;
      rej_q     <= 1'b0;
      result_q  <= '0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
      result_q  <= result_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign core_start_o        = start_q;

`ifdef RE2_COPRO_IRQ_EN
  assign irq_o = irq_q;
  logic unused_sink;
  assign unused_sink = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr_q[1:0],
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
`else
  // IRQ enable bit is stored but has no output without the feature.
  logic unused_sink;
  assign unused_sink = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr_q[1:0],
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], irq_q};
`endif

endmodule

// File: tb/tb_re2_copro_axil_regs.sv
// Scoreboard bench for re2_copro_axil_regs (define RE2_COPRO_IRQ_EN to cover irq_o).
module tb_re2_copro_axil_regs;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        core_start;
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  logic [31:0] core_result = '0;
`ifdef RE2_COPRO_IRQ_EN
  logic        irq;
`endif

  re2_copro_axil_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  re2_copro_axil_regs dut (
    .ACLK          (aclk),
    .ARESETN       (aresetn),
    .s_axi         (bus.slave),
    .core_start_o  (core_start),
    .core_busy_i   (core_busy),
    .core_done_i   (core_done),
    .core_result_i (core_result)
`ifdef RE2_COPRO_IRQ_EN
    ,
    .irq_o         (irq)
`endif
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];
  logic [1:0]  b_e;
  logic [33:0] r_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare responses whenever the DUT completes B or R.
  always @(negedge aclk) begin
    if (aresetn && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
      if (b_exp_q.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
      else begin
        b_e = b_exp_q.pop_front();
        chk("bresp", 32'(bus.S_AXI_BRESP), 32'(b_e));
      end
    end
    if (aresetn && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
      if (r_exp_q.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
      else begin
        r_e = r_exp_q.pop_front();
        chk("rdata", bus.S_AXI_RDATA, r_e[31:0]);
        chk("rresp", 32'(bus.S_AXI_RRESP), 32'(r_e[33:32]));
      end
    end
    if (aresetn && core_start) start_cnt++;
  end

  task automatic aw_send(input logic [4:0] a, input int dly);
    repeat (dly) @(posedge aclk);
    #1;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (bus.S_AXI_AWREADY) break;
      if (n == 49) chk("aw_timeout", 32'd1, 32'd0);
    end
    @(posedge aclk);
    #1 bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] st, input int dly);
    repeat (dly) @(posedge aclk);
    #1;
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = st;
    bus.S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (bus.S_AXI_WREADY) break;
      if (n == 49) chk("w_timeout", 32'd1, 32'd0);
    end
    @(posedge aclk);
    #1 bus.S_AXI_WVALID = 1'b0;
  endtask

  task automatic wait_low_b();
    for (int n = 0; n < 50 && bus.S_AXI_BVALID; n++) begin
      @(posedge aclk);
      #1;
    end
    if (bus.S_AXI_BVALID) chk("b_drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
    b_exp_q.push_back(exp_resp);
    fork
      aw_send(a, aw_dly);
      w_send(d, st, w_dly);
    join
    // Now one cycle after the later handshake edge.
    chk("b_latency", 32'(bus.S_AXI_BVALID), 32'd1);
    wait_low_b();
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_r, input int stall);
    logic [31:0] held;
    r_exp_q.push_back({exp_r, exp_d});
    if (stall > 0) bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (bus.S_AXI_ARREADY) break;
      if (n == 49) chk("ar_timeout", 32'd1, 32'd0);
    end
    @(posedge aclk);
    #1 bus.S_AXI_ARVALID = 1'b0;
    if (stall > 0) begin
      chk("r_latency", 32'(bus.S_AXI_RVALID), 32'd1);
      held = bus.S_AXI_RDATA;
      repeat (stall) begin
        @(negedge aclk);
        chk("r_stall_valid", 32'(bus.S_AXI_RVALID), 32'd1);
        chk("r_stall_data", bus.S_AXI_RDATA, held);
      end
      @(posedge aclk);
      #1 bus.S_AXI_RREADY = 1'b1;
    end
    for (int n = 0; n < 50; n++) begin
      @(posedge aclk);
      #1;
      if (!bus.S_AXI_RVALID) break;
      if (n == 49) chk("r_drain_timeout", 32'd1, 32'd0);
    end
  endtask

  // Pulses core_done in the same cycle a pending write commits.
  task automatic done_on_commit(input logic [31:0] res);
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY && bus.S_AXI_WVALID && bus.S_AXI_WREADY) break;
      if (n == 49) chk("commit_timeout", 32'd1, 32'd0);
    end
    core_done   = 1'b1;
    core_result = res;
    @(posedge aclk);
    #1 core_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    // Reset values
    #12;
    chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    chk("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    chk("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    chk("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    chk("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
    chk("rst_start",   32'(core_start),        32'd0);
    #10 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    axi_read(5'h00, 32'h0, 2'b00, 0);
    axi_read(5'h14, 32'h0, 2'b00, 0);

    // Test 1: basic R/W and single start pulse
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 2'b00);
    axi_write(5'h04, 32'h2, 4'hF, 0, 0, 2'b00);
    axi_write(5'h08, 32'h3, 4'hF, 0, 0, 2'b00);
    axi_write(5'h0C, 32'h4, 4'hF, 0, 0, 2'b00);
    axi_read(5'h00, 32'h1, 2'b00, 0);
    axi_read(5'h04, 32'h2, 2'b00, 0);
    axi_read(5'h08, 32'h3, 2'b00, 0);
    axi_read(5'h0C, 32'h4, 2'b00, 0);
    chk("start_count_t1", 32'(start_cnt), 32'd1);

    // Test 2: AW/W ordering with byte strobes
    axi_write(5'h04, 32'h11223344, 4'hF, 0, 0, 2'b00);
    axi_write(5'h04, 32'hAABBCCDD, 4'b0010, 0, 3, 2'b00);
    axi_read(5'h04, 32'h1122CC44, 2'b00, 0);
    axi_write(5'h04, 32'hAABB99DD, 4'b0010, 3, 0, 2'b00);
    axi_read(5'h04, 32'h11229944, 2'b00, 0);

    // Test 3: start rejected while busy, then cleared
    core_busy = 1'b1;
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 2'b00);
    repeat (2) @(posedge aclk);
    #1 chk("start_count_busy", 32'(start_cnt), 32'd1);
    axi_read(5'h10, 32'h5, 2'b00, 0);
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 2'b00);
    axi_read(5'h10, 32'h1, 2'b00, 0);
    core_busy = 1'b0;

    // Test 4: done coincident with clear - set wins
    fork
      axi_write(5'h00, 32'h2, 4'hF, 0, 0, 2'b00);
      done_on_commit(32'hDEADBEEF);
    join
    axi_read(5'h14, 32'hDEADBEEF, 2'b00, 0);
    axi_read(5'h10, 32'h2, 2'b00, 0);

    // Test 5: SLVERR paths, read stall stability
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10);
    axi_write(5'h14, 32'h12345678, 4'hF, 0, 0, 2'b10);
    axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10);
    axi_read(5'h10, 32'h2, 2'b00, 0);
    axi_read(5'h14, 32'hDEADBEEF, 2'b00, 0);
    axi_read(5'h18, 32'h0, 2'b10, 4);
    axi_read(5'h0C, 32'h4, 2'b00, 4);
    chk("start_count_final", 32'(start_cnt), 32'd1);

`ifdef RE2_COPRO_IRQ_EN
    // Test 6: interrupt follows irq_en & done
    axi_write(5'h00, 32'h6, 4'hF, 0, 0, 2'b00);
    repeat (2) @(posedge aclk);
    #1 chk("irq_cleared", 32'(irq), 32'd0);
    core_done = 1'b1; core_result = 32'h00000042;
    @(posedge aclk);
    #1 core_done = 1'b0;
    repeat (2) @(posedge aclk);
    #1 chk("irq_set", 32'(irq), 32'd1);
    axi_write(5'h00, 32'h6, 4'hF, 0, 0, 2'b00);
    repeat (2) @(posedge aclk);
    #1 chk("irq_clr", 32'(irq), 32'd0);
    axi_read(5'h14, 32'h00000042, 2'b00, 0);
`endif

    // Async reset with a B response pending
    bus.S_AXI_BREADY = 1'b0;
    fork
      aw_send(5'h08, 0);
      w_send(32'h55, 4'hF, 0);
    join
    chk("b_pending", 32'(bus.S_AXI_BVALID), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    chk("arst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    chk("arst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    chk("arst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    chk("arst_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
    chk("arst_rdata",   bus.S_AXI_RDATA,        32'd0);
`ifdef RE2_COPRO_IRQ_EN
    chk("arst_irq",     32'(irq),               32'd0);
`endif
    chk("b_queue_empty", 32'(b_exp_q.size()), 32'd0);
    chk("r_queue_empty", 32'(r_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
